// File: rtl/drive_pkg.sv
// drive_pkg: shared widths, requester indices and FSM state type for the drive arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package drive_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF  = 8;

  localparam int REQ_CPU = 0;
  localparam int REQ_GPU = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    TURN = 2'd2
  } drv_state_t;

endpackage

// File: rtl/drive_rr_arbiter.sv
// drive_rr_arbiter: 2-way round-robin grant; contention goes to the requester not granted last.
// Latency: grant is combinational from req/en; last_grant updates on the clock after a grant.
// Backpressure: no grant while en is low; losing requester simply keeps requesting.
module drive_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  // last_grant starts at 1 so the first contended grant goes to requester 0
  logic last_grant_q;
  logic last_grant_d;

  // pick the winner and remember who it was
  always_comb begin
    grant        = 2'b00;
    last_grant_d = last_grant_q;
    if (en && (req != 2'b00)) begin
      if (req == 2'b11) begin
        grant = last_grant_q ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
      last_grant_d = grant[1];
    end
  end

  // last_grant register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/drive_arbiter.sv
// drive_arbiter: shares the external 16-bit drive between CPU (0) and GPU loader (1) as bursts.
// Latency: accept in IDLE, first beat next cycle, rd_data/rd_valid one cycle after each read beat.
// Backpressure: req_ready pulses on accept; write beats stall while wr_valid is low; reads never stall.
module drive_arbiter
  import drive_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                r,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*LEN_W-1:0]  req_len,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] wr_data,
  input  logic [1:0]          wr_valid,
  output logic [1:0]          wr_ack,
  output logic [DATA_W-1:0]   rd_data,
  output logic [1:0]          rd_valid,
  output logic [1:0]          done,
  output logic [ADDR_W-1:0]   drv_addr,
  inout  wire  [DATA_W-1:0]   drv_bus,
  output logic                drv_we,
  output logic                drv_oe
);

  drv_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [1:0]        rd_valid_q, rd_valid_d;
  logic [1:0]        done_q, done_d;

  logic [1:0]        grant;
  logic              arb_en;
  logic              gsel;
  logic              own_wr_valid;
  logic [DATA_W-1:0] own_wr_data;
  logic              bus_en;
  logic              beat;

  // arbitration only while idle and out of reset, so reset forces req_ready low immediately
  assign arb_en = (state_q == IDLE) && !r;
  assign gsel   = grant[REQ_GPU];

  drive_rr_arbiter u_rr (
    .clk   (clk),
    .rst   (r),
    .req   (req_valid),
    .en    (arb_en),
    .grant (grant)
  );

  assign own_wr_valid = owner_q ? wr_valid[REQ_GPU] : wr_valid[REQ_CPU];
  assign own_wr_data  = owner_q ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0];

  // bus is only driven on an actual write beat; read beats and idle leave it floating
  assign drv_bus  = bus_en ? own_wr_data : {DATA_W{1'bz}};
  assign drv_addr = cur_addr_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign done     = done_q;

  // next-state, counters and combinational drive controls
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    write_d     = write_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 2'b00;
    done_d      = 2'b00;
    req_ready   = 2'b00;
    wr_ack      = 2'b00;
    drv_oe      = 1'b0;
    drv_we      = 1'b0;
    bus_en      = 1'b0;
    beat        = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          req_ready   = grant;
          owner_d     = gsel;
          write_d     = gsel ? req_write[REQ_GPU] : req_write[REQ_CPU];
          cur_addr_d  = gsel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          remaining_d = gsel ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
          state_d     = XFER;
        end
      end
      XFER: begin
        if (write_q) begin
          if (own_wr_valid) begin
            drv_we          = 1'b1;
            bus_en          = 1'b1;
            wr_ack[owner_q] = 1'b1;
            beat            = 1'b1;
          end
        end else begin
          drv_oe              = 1'b1;
          rd_data_d           = drv_bus;
          rd_valid_d[owner_q] = 1'b1;
          beat                = 1'b1;
        end
        if (beat) begin
          cur_addr_d  = cur_addr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == '0) begin
            done_d[owner_q] = 1'b1;
            state_d         = TURN;
          end
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state registers; reset abandons any burst without a done pulse
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      write_q     <= 1'b0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 2'b00;
      done_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      write_q     <= write_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_drive_arbiter.sv
// tb_drive_arbiter: requester agents feed commands; a negedge monitor scores every drive beat,
// read strobe, done pulse and grant against expectations queued at command acceptance.
// The drive model returns 0xA000 + addr[15:0] on reads and records writes into a sparse memory.
module tb_drive_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic r   = 1'b1;
  always #5 clk = ~clk;

  wire  [1:0]      req_valid, req_write, wr_valid;
  wire  [2*AW-1:0] req_addr;
  wire  [2*LW-1:0] req_len;
  wire  [2*DW-1:0] wr_data;
  logic [1:0]      req_ready, wr_ack, rd_valid, done;
  logic [DW-1:0]   rd_data;
  logic [AW-1:0]   drv_addr;
  wire  [DW-1:0]   drv_bus;
  logic            drv_we, drv_oe;

  drive_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .r(r),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .req_ready(req_ready), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ack(wr_ack),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
    .drv_addr(drv_addr), .drv_bus(drv_bus), .drv_we(drv_we), .drv_oe(drv_oe)
  );

  // drive model: answers reads on the same cycle it is enabled
  assign drv_bus = drv_oe ? (16'hA000 + drv_addr[15:0]) : {DW{1'bz}};

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [DW-1:0] nonce;
    int            stall_beat;
    int            stall_len;
  } cmd_t;

  int errors = 0;
  int checks = 0;
  int nissued = 0;

  task automatic chk(bit ok, string name, longint act, longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // requester agents: word i of a write burst is nonce+i
  for (genvar g = 0; g < 2; g++) begin : ag
    cmd_t          cq[$];
    logic          v = 1'b0, w = 1'b0, wv = 1'b0;
    logic [AW-1:0] a = '0;
    logic [LW-1:0] l = '0;
    logic [DW-1:0] wd = '0;
    assign req_valid[g]        = v;
    assign req_write[g]        = w;
    assign wr_valid[g]         = wv;
    assign req_addr[g*AW +: AW] = a;
    assign req_len[g*LW +: LW]  = l;
    assign wr_data[g*DW +: DW]  = wd;

    initial begin
      cmd_t c;
      bit   acc;
      int   beat, cyc, n;
      forever begin
        @(posedge clk); #1;
        if (cq.size() != 0) begin
          c = cq.pop_front();
          v = 1'b1; w = c.wr; a = c.addr; l = c.len; wd = c.nonce; wv = 1'b0;
          acc = 1'b0;
          for (n = 0; n < 3000 && !acc; n++) begin
            @(negedge clk);
            acc = req_ready[g];
          end
          @(posedge clk); #1;
          v = 1'b0;
          if (acc && c.wr) begin
            beat = 0; cyc = 0; n = 0;
            while (beat <= int'(c.len) && !r && n < 3000) begin
              wv = !(beat == c.stall_beat && cyc < c.stall_len);
              wd = c.nonce + DW'(beat);
              @(negedge clk);
              if (wr_ack[g]) beat++;
              else if (beat == c.stall_beat) cyc++;
              @(posedge clk); #1;
              n++;
            end
            wv = 1'b0;
          end
        end
      end
    end
  end

  // scoreboard state
  logic [AW-1:0] aq[$];
  logic [DW-1:0] rdq[$];
  logic [DW-1:0] wdq[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            glog[$];
  bit            last_m = 1'b1, own_m = 1'b0, cur_wr = 1'b0;
  bit            done_pend = 1'b0, first_pend = 1'b0, first_strobe = 1'b0;
  int            cur_len = 0, cnt = 0, acc_cyc = 0, last_beat_cyc = -100, cyc = 0;

  // monitor: compares every DUT presentation against queued expectations
  initial begin : mon
    logic [AW-1:0] ea, base;
    logic [DW-1:0] ed, fd;
    logic [1:0]    ohm, exp_ack;
    bit            win;
    int            wi;
    forever begin
      @(negedge clk);
      cyc++;
      if (r) begin
        aq.delete(); rdq.delete(); wdq.delete();
        last_m = 1'b1; done_pend = 1'b0; first_pend = 1'b0; first_strobe = 1'b0;
        last_beat_cyc = -100;
      end else begin
        ohm = own_m ? 2'b10 : 2'b01;
        chk(!(drv_oe && drv_we), "oe_we_exclusive", {drv_oe, drv_we}, 0);
        exp_ack = drv_we ? ohm : 2'b00;
        chk(wr_ack == exp_ack, "wr_ack", wr_ack, exp_ack);
        chk(!drv_we || wr_valid[own_m], "we_without_wr_valid", wr_valid, ohm);
        if (wr_ack != 2'b00) cnt++;
        if (drv_oe || drv_we) begin
          if (first_pend) begin
            chk(cyc - last_beat_cyc >= 3, "min_gap", cyc - last_beat_cyc, 3);
            first_pend = 1'b0;
          end
          chk(drv_oe == !cur_wr, "beat_direction", drv_oe, !cur_wr);
          chk(aq.size() != 0, "beat_expected", drv_addr, 0);
          if (aq.size() != 0) begin
            ea = aq.pop_front();
            chk(drv_addr == ea, "drv_addr", drv_addr, ea);
            if (aq.size() == 0) last_beat_cyc = cyc;
          end
          if (drv_we && wdq.size() != 0) begin
            ed = wdq.pop_front();
            chk(drv_bus == ed, "write_bus", drv_bus, ed);
            mem[drv_addr] = drv_bus;
          end
        end
        if (rd_valid != 2'b00) begin
          chk(rd_valid == ohm, "rd_valid_owner", rd_valid, ohm);
          chk(rdq.size() != 0, "rd_expected", rd_data, 0);
          if (rdq.size() != 0) begin
            ed = rdq.pop_front();
            chk(rd_data == ed, "rd_data", rd_data, ed);
          end
          if (first_strobe) begin
            chk(cyc - acc_cyc == 2, "rd_first_latency", cyc - acc_cyc, 2);
            first_strobe = 1'b0;
          end
          cnt++;
        end
        if (done != 2'b00) begin
          chk(done_pend, "done_expected", done, 0);
          chk(done == ohm, "done_owner", done, ohm);
          chk(cnt == cur_len + 1, "burst_words", cnt, cur_len + 1);
          chk(aq.size() == 0, "beats_left_at_done", aq.size(), 0);
          if (!cur_wr) chk(rd_valid == ohm, "done_with_last_strobe", rd_valid, ohm);
          done_pend = 1'b0;
        end
        if (req_ready != 2'b00) begin
          chk($countones(req_ready) == 1, "ready_onehot", req_ready, 1);
          chk(!done_pend && aq.size() == 0, "accept_while_busy", aq.size(), 0);
          win = (req_valid == 2'b11) ? !last_m : req_valid[1];
          chk(req_ready == (win ? 2'b10 : 2'b01), "grant", req_ready, win ? 2 : 1);
          last_m = win; own_m = win; glog.push_back(int'(win));
          wi      = int'(win);
          cur_wr  = req_write[wi];
          base    = req_addr[wi*AW +: AW];
          cur_len = int'(req_len[wi*LW +: LW]);
          fd      = wr_data[wi*DW +: DW];
          for (int i = 0; i <= cur_len; i++) begin
            aq.push_back(base + AW'(i));
            if (cur_wr) wdq.push_back(fd + DW'(i));
            else        rdq.push_back(16'hA000 + DW'(base + AW'(i)));
          end
          cnt = 0; acc_cyc = cyc; first_pend = 1'b1;
          first_strobe = !cur_wr; done_pend = 1'b1;
        end
      end
    end
  end

  task automatic issue(int k, bit wr, logic [AW-1:0] a, logic [LW-1:0] l,
                       logic [DW-1:0] nz, int sb, int sl);
    cmd_t c;
    c.wr = wr; c.addr = a; c.len = l; c.nonce = nz; c.stall_beat = sb; c.stall_len = sl;
    if (k == 0) ag[0].cq.push_back(c);
    else        ag[1].cq.push_back(c);
    nissued++;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while ((ag[0].cq.size() != 0 || ag[1].cq.size() != 0 || ag[0].v || ag[1].v ||
            aq.size() != 0 || done_pend) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(n < 5000, {"drain_", name}, n, 5000);
    repeat (3) @(negedge clk);
  endtask

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
    $fatal(1);
  end

  initial begin : main
    int n;
    // both requesters hold len-0 reads across reset release
    issue(0, 1'b0, 24'h000400, 8'd0, 16'h0, -1, 0);
    issue(1, 1'b0, 24'h000500, 8'd0, 16'h0, -1, 0);
    issue(0, 1'b0, 24'h000401, 8'd0, 16'h0, -1, 0);
    issue(1, 1'b0, 24'h000501, 8'd0, 16'h0, -1, 0);
    @(negedge clk);
    chk({req_ready, wr_ack, rd_valid, done, drv_oe, drv_we} == 10'd0, "reset_ctrl_outputs",
        {req_ready, wr_ack, rd_valid, done, drv_oe, drv_we}, 0);
    chk(drv_addr == '0, "reset_drv_addr", drv_addr, 0);
    chk(rd_data == '0, "reset_rd_data", rd_data, 0);
    repeat (3) @(posedge clk);
    #2 r = 1'b0;
    wait_idle("arbitration");
    chk(glog.size() == 4, "grant_log_size", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      chk(glog[i] == (i % 2), "grant_order", glog[i], i % 2);

    // read 4 words starting at 0x10
    issue(0, 1'b0, 24'h000010, 8'd3, 16'h0, -1, 0);
    wait_idle("read_basic");

    // write 3 words with a 3-cycle stall on the second word
    issue(1, 1'b1, 24'h000100, 8'd2, 16'h5000, 1, 3);
    wait_idle("write_stall");
    for (int i = 0; i < 3; i++) begin
      logic [AW-1:0] ad;
      ad = 24'h000100 + AW'(i);
      chk(mem.exists(ad) && mem[ad] == 16'h5000 + DW'(i), "write_memory",
          mem.exists(ad) ? mem[ad] : 16'hDEAD, 16'h5000 + i);
    end

    // address wrap across the top of the drive
    issue(0, 1'b0, 24'hFFFFFE, 8'd3, 16'h0, -1, 0);
    wait_idle("addr_wrap");

    // maximum-length read
    issue(1, 1'b0, 24'h123456, 8'd255, 16'h0, -1, 0);
    wait_idle("max_len");

    // reset in the middle of beat 2 of a 5-word write
    issue(0, 1'b1, 24'h000200, 8'd4, 16'h7700, -1, 0);
    n = 0;
    while (!(done_pend && cur_wr && cnt >= 1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(n < 300, "reach_beat2", n, 300);
    @(posedge clk); #3;
    chk(drv_we == 1'b1, "beat2_active", drv_we, 1);
    r = 1'b1;
    #1;
    chk({drv_we, drv_oe} == 2'b00, "reset_kills_drive", {drv_we, drv_oe}, 0);
    chk(wr_ack == 2'b00 && req_ready == 2'b00, "reset_kills_handshake", {wr_ack, req_ready}, 0);
    repeat (2) @(posedge clk);
    #2 r = 1'b0;
    issue(1, 1'b0, 24'h000300, 8'd2, 16'h0, -1, 0);
    wait_idle("after_reset");

    // randomized traffic from both requesters
    for (int k = 0; k < 40; k++) begin
      logic [AW-1:0] ra;
      logic [LW-1:0] rl;
      rl = LW'($urandom_range(0, 6));
      ra = ($urandom_range(0, 3) == 0) ? AW'(24'hFFFFF8 + $urandom_range(0, 7)) : AW'($urandom);
      issue(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rl, DW'($urandom),
            int'($urandom_range(0, int'(rl))), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 8)) @(posedge clk);
    end
    wait_idle("random");
    chk(glog.size() == nissued, "grant_count", glog.size(), nissued);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
